// File: rtl/bexkat_lsu_if.sv
// Wishbone-style system bus between the LSU (master) and memory (slave).
// Carries one beat per cycle of cyc_o; ack_i/err_i terminate the beat.
interface bexkat_lsu_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   adr_o;
  logic            cyc_o;
  logic            we_o;
  logic [DW/8-1:0] sel_o;
  logic [DW-1:0]   dat_o;
  logic [DW-1:0]   dat_i;
  logic            ack_i;
  logic            err_i;

  modport master (
    output adr_o, cyc_o, we_o, sel_o, dat_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  adr_o, cyc_o, we_o, sel_o, dat_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/bexkat_lsu.sv
// Load/store bus master: byte..dword accesses on big-endian lanes, misaligned accesses split
// into two beats, per-beat watchdog. Single-beat latency: accept -> beat -> response pulse.
module bexkat_lsu #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_signed_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          rsp_valid_o,
  output logic [DW-1:0] rsp_rdata_o,
  output logic [1:0]    rsp_err_o,
  bexkat_lsu_if.master  bus
);

  localparam int NB  = DW / 8;
  localparam int OW  = $clog2(NB);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] TO_M1 = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t          state, state_nxt;
  logic            r_we, r_signed;
  logic [1:0]      r_size;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_acc;
  logic [WDW-1:0]  wd;

  logic [AW-1:0]   src_addr;
  logic [1:0]      src_size;
  logic [DW-1:0]   src_wdata;
  int              off_i, n_i, lane_o, k0, k1;
  logic            split, illegal, sgn, timeout;
  logic [NB-1:0]   sel0, sel1;
  logic [DW-1:0]   dat0, dat1, cap, ext, shv, shs;

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign timeout     = (TIMEOUT != 0) && (wd == TO_M1);

  // Lane steering: in IDLE it prepares BEAT0 from the live request, otherwise from the registered one.
  always_comb begin
    src_addr  = (state == IDLE) ? req_addr_i  : r_addr;
    src_size  = (state == IDLE) ? req_size_i  : r_size;
    src_wdata = (state == IDLE) ? req_wdata_i : r_wdata;
    off_i     = int'(src_addr[OW-1:0]);
    n_i       = 1 << src_size;
    split     = (off_i + n_i) > NB;
    illegal   = n_i > NB;
    sel0      = '0;
    sel1      = '0;
    dat0      = '0;
    dat1      = '0;
    cap       = r_acc;
    shv       = '0;
    lane_o    = 0;
    k0        = 0;
    k1        = 0;
    for (int j = 0; j < NB; j++) begin
      lane_o = NB - 1 - j;
      k0     = lane_o - off_i;
      k1     = NB - off_i + lane_o;
      if (k0 >= 0 && k0 < n_i) begin
        sel0[j]        = 1'b1;
        shv            = src_wdata >> (8 * (n_i - 1 - k0));
        dat0[8*j +: 8] = shv[7:0];
        if (state == BEAT0)
          cap = cap | (DW'(bus.dat_i[8*j +: 8]) << (8 * (n_i - 1 - k0)));
      end
      if (k1 < n_i) begin
        sel1[j]        = 1'b1;
        shv            = src_wdata >> (8 * (n_i - 1 - k1));
        dat1[8*j +: 8] = shv[7:0];
        if (state == BEAT1)
          cap = cap | (DW'(bus.dat_i[8*j +: 8]) << (8 * (n_i - 1 - k1)));
      end
    end
    shs = cap >> (8 * n_i - 1);
    sgn = r_signed & shs[0];
    ext = cap;
    for (int i = 0; i < NB; i++) begin
      if (i >= n_i && sgn)
        ext[8*i +: 8] = 8'hFF;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid_i) state_nxt = illegal ? RESP : BEAT0;
      BEAT0: if (bus.err_i)                  state_nxt = RESP;
             else if (bus.ack_i)             state_nxt = split ? BEAT1 : RESP;
             else if (timeout)               state_nxt = RESP;
      BEAT1: if (bus.err_i || bus.ack_i || timeout) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we        <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_acc       <= '0;
      wd          <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 2'd0;
      bus.adr_o   <= '0;
      bus.cyc_o   <= 1'b0;
      bus.we_o    <= 1'b0;
      bus.sel_o   <= '0;
      bus.dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            r_we        <= req_we_i;
            r_signed    <= req_signed_i;
            r_size      <= req_size_i;
            r_addr      <= req_addr_i;
            r_wdata     <= req_wdata_i;
            r_acc       <= '0;
            wd          <= '0;
            rsp_rdata_o <= '0;
            if (illegal) begin
              rsp_err_o <= 2'd3;
            end else begin
              rsp_err_o <= 2'd0;
              bus.cyc_o <= 1'b1;
              bus.we_o  <= req_we_i;
              bus.adr_o <= {req_addr_i[AW-1:OW], {OW{1'b0}}};
              bus.sel_o <= sel0;
              bus.dat_o <= req_we_i ? dat0 : '0;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (bus.err_i || (!bus.ack_i && timeout)) begin
            bus.cyc_o   <= 1'b0;
            bus.we_o    <= 1'b0;
            bus.sel_o   <= '0;
            bus.dat_o   <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= bus.err_i ? 2'd1 : 2'd2;
          end else if (bus.ack_i) begin
            if (state == BEAT0 && split) begin
              r_acc     <= cap;
              wd        <= '0;
              bus.adr_o <= bus.adr_o + AW'(NB);
              bus.sel_o <= sel1;
              bus.dat_o <= r_we ? dat1 : '0;
            end else begin
              bus.cyc_o   <= 1'b0;
              bus.we_o    <= 1'b0;
              bus.sel_o   <= '0;
              bus.dat_o   <= '0;
              rsp_rdata_o <= r_we ? '0 : ext;
              rsp_err_o   <= 2'd0;
            end
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
